// File: rtl/systolic_feeder_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array feeder:
//   feed_state_e : controller states (IDLE, LOAD_W, STREAM, DRAIN)
//   N_DEF        : default array rows/columns
//   X_W_DEF      : default activation width
//   W_W_DEF      : default weight width
//   cnt_width()  : width of a counter that indexes 0..n-1 (never below 1)
// ---------------------------------------------------------------------------
package systolic_pkg;

    localparam int N_DEF   = 8;
    localparam int X_W_DEF = 9;
    localparam int W_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feed_state_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_if
// Handshake bundle between a weight/activation source and the feeder.
//   w_data  : one weight row, N signed lanes of W_W bits
//   w_v     : weight row valid
//   w_rdy   : weight row ready (row accepted when w_v && w_rdy)
//   in_data : one activation vector, N signed lanes of X_W bits
//   in_v    : activation vector valid
//   in_last : final vector of a batch, qualified by in_v
//   in_rdy  : activation ready (vector accepted when in_v && in_rdy)
// Modports: master = source side, slave = feeder side.
// ---------------------------------------------------------------------------
interface systolic_feeder_if
    import systolic_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int X_W = X_W_DEF,
    parameter int W_W = W_W_DEF
) ();

    logic [N*W_W-1:0] w_data;
    logic             w_v;
    logic             w_rdy;
    logic [N*X_W-1:0] in_data;
    logic             in_v;
    logic             in_last;
    logic             in_rdy;

    modport master (
        output w_data, w_v, in_data, in_v, in_last,
        input  w_rdy, in_rdy
    );

    modport slave (
        input  w_data, w_v, in_data, in_v, in_last,
        output w_rdy, in_rdy
    );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// ---------------------------------------------------------------------------
// skew_line
// One lane of the activation skew: a DEPTH-stage delay line with a valid
// bit per stage.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   d_i, v_i     : lane data and its valid strobe
//   q_o, v_o     : data and valid after DEPTH cycles
// ---------------------------------------------------------------------------
module skew_line
    import systolic_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = X_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] q_o,
    output logic             v_o
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Data stages only move when the stage feeding them holds a valid word,
    // so idle cycles leave the lane data parked instead of toggling it.
    // Valid bits shift every cycle so bubbles travel with the data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (v_i) begin
                data_q[0] <= d_i;
            end
            valid_q[0] <= v_i;
            for (int i = 1; i < DEPTH; i++) begin
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign q_o = data_q[DEPTH-1];
    assign v_o = valid_q[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Loads N weight rows into a systolic array, then streams activation
// vectors into it with a diagonal skew (lane k delayed by k+1 cycles),
// drains for N cycles after the last vector and pulses done.
//   clk_i, rst_i  : clock, asynchronous active-low reset
//   bus (slave)   : weight and activation handshakes
//   w_o           : registered weight row broadcast to all array rows
//   w_wr_en_o     : one-hot row write enable, high for one cycle per row
//   x_o, x_v_o    : skewed activations and per-lane valid
//   mac_top_v_o   : top-row partial-sum valid (same as x_v_o)
//   busy_o        : controller not idle
//   done_o        : one-cycle pulse after the drain completes
//   vec_cnt_o     : accepted vectors in the current batch, saturating
//                   (present only when FEEDER_PERF_EN is defined)
// ---------------------------------------------------------------------------
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int X_W = X_W_DEF,
    parameter int W_W = W_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    systolic_feeder_if.slave   bus,
    output logic [N*W_W-1:0]   w_o,
    output logic [N-1:0]       w_wr_en_o,
    output logic [N*X_W-1:0]   x_o,
    output logic [N-1:0]       x_v_o,
    output logic [N-1:0]       mac_top_v_o,
    output logic               busy_o,
    output logic               done_o
`ifdef FEEDER_PERF_EN
    ,
    output logic [15:0]        vec_cnt_o
`endif
);

    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    feed_state_e      state_q, state_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] drain_q, drain_d;
    logic             done_d;
    logic             w_acc;
    logic             in_acc;

    assign w_acc  = bus.w_v && ((state_q == IDLE) || (state_q == LOAD_W));
    assign in_acc = bus.in_v && (state_q == STREAM);

    // Controller state, row counter and drain counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            drain_q <= '0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            drain_q <= drain_d;
            done_o  <= done_d;
        end
    end

    // Next-state logic and ready outputs. IDLE and LOAD_W behave the same
    // towards the weight port; the row counter is always 0 in IDLE, so the
    // first accepted row lands in row 0.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        bus.w_rdy  = 1'b0;
        bus.in_rdy = 1'b0;
        case (state_q)
            IDLE, LOAD_W: begin
                bus.w_rdy = 1'b1;
                if (bus.w_v) begin
                    if (row_q == LAST_IDX) begin
                        state_d = STREAM;
                        row_d   = '0;
                    end else begin
                        state_d = LOAD_W;
                        row_d   = row_q + 1'b1;
                    end
                end
            end
            STREAM: begin
                bus.in_rdy = 1'b1;
                if (bus.in_v && bus.in_last) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == LAST_IDX) begin
                    state_d = IDLE;
                    drain_d = '0;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Weight row register and one-hot write enable, both one cycle after
    // acceptance. The row value is held between writes.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            w_o       <= '0;
            w_wr_en_o <= '0;
        end else begin
            w_wr_en_o <= '0;
            if (w_acc) begin
                w_o              <= bus.w_data;
                w_wr_en_o[row_q] <= 1'b1;
            end
        end
    end

    // Lane k gets k+1 stages so vectors enter the array diagonally.
    for (genvar k = 0; k < N; k++) begin : g_lane
        skew_line #(
            .DEPTH (k + 1),
            .WIDTH (X_W)
        ) u_skew (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (bus.in_data[k*X_W +: X_W]),
            .v_i   (in_acc),
            .q_o   (x_o[k*X_W +: X_W]),
            .v_o   (x_v_o[k])
        );
    end

    assign mac_top_v_o = x_v_o;
    assign busy_o      = (state_q != IDLE);

`ifdef FEEDER_PERF_EN
    logic [15:0] vec_cnt_q;

    // Batch vector counter: restarts on every entry to STREAM so it reports
    // the current batch only, and sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vec_cnt_q <= '0;
        end else if ((state_q != STREAM) && (state_d == STREAM)) begin
            vec_cnt_q <= '0;
        end else if (in_acc && (vec_cnt_q != 16'hFFFF)) begin
            vec_cnt_q <= vec_cnt_q + 16'd1;
        end
    end

    assign vec_cnt_o = vec_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
// Directed scenarios with literal expectations followed by randomized
// traffic, all outputs compared every cycle against a behavioural model.
// Optional feature macro: FEEDER_PERF_EN (vec_cnt_o).
// ---------------------------------------------------------------------------
module tb_systolic_feeder;
    import systolic_pkg::*;

    localparam int N           = N_DEF;
    localparam int X_W         = X_W_DEF;
    localparam int W_W         = W_W_DEF;
    localparam int RAND_CYCLES = 3000;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    systolic_feeder_if #(.N(N), .X_W(X_W), .W_W(W_W)) bus ();

    logic [N*W_W-1:0] w_o;
    logic [N-1:0]     w_wr_en_o;
    logic [N*X_W-1:0] x_o;
    logic [N-1:0]     x_v_o;
    logic [N-1:0]     mac_top_v_o;
    logic             busy_o;
    logic             done_o;
`ifdef FEEDER_PERF_EN
    logic [15:0]      vec_cnt_o;
`endif

    systolic_feeder #(.N(N), .X_W(X_W), .W_W(W_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .bus         (bus),
        .w_o         (w_o),
        .w_wr_en_o   (w_wr_en_o),
        .x_o         (x_o),
        .x_v_o       (x_v_o),
        .mac_top_v_o (mac_top_v_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
`ifdef FEEDER_PERF_EN
        ,
        .vec_cnt_o   (vec_cnt_o)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Compare one observed value with its required value and log misses.
    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; they stay stable through the next rising edge.
    task automatic applyStimulus(input logic wv, input logic [N*W_W-1:0] wd,
                                 input logic iv, input logic [N*X_W-1:0] xd,
                                 input logic il);
        @(negedge clk_i);
        bus.w_v     = wv;
        bus.w_data  = wd;
        bus.in_v    = iv;
        bus.in_data = xd;
        bus.in_last = il;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    // Reset pulse landing between clock edges, released on a falling edge.
    task automatic applyReset();
        @(posedge clk_i);
        #2;
        rst_i       = 1'b0;
        bus.w_v     = 1'b0;
        bus.in_v    = 1'b0;
        bus.in_last = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    function automatic logic [N*W_W-1:0] rowAll(input int v);
        logic [N*W_W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W_W +: W_W] = W_W'(v);
        return r;
    endfunction

    function automatic logic [N*X_W-1:0] randVec();
        logic [N*X_W-1:0] r;
        for (int k = 0; k < N; k++) r[k*X_W +: X_W] = X_W'($urandom);
        return r;
    endfunction

    function automatic logic [N*W_W-1:0] randRow();
        logic [N*W_W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W_W +: W_W] = W_W'($urandom);
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    // Phase of the batch, weight rows taken so far, drain cycles remaining,
    // and a history of the last N acceptance cycles: lane k shows the entry
    // accepted k+1 cycles ago and keeps its last valid word otherwise.
    typedef enum {M_IDLE, M_LOAD, M_STREAM, M_DRAIN} mode_t;

    mode_t            m_mode  = M_IDLE;
    int               m_rows  = 0;
    int               m_drain = 0;
    int               m_vec   = 0;
    logic             m_done  = 1'b0;
    logic [N-1:0]     m_wen   = '0;
    logic [N*W_W-1:0] m_w     = '0;
    logic [N-1:0]     m_xv    = '0;
    logic [N*X_W-1:0] m_x     = '0;
    bit               hist_v[$];
    logic [N*X_W-1:0] hist_d[$];

    task automatic modelReset();
        m_mode  = M_IDLE;
        m_rows  = 0;
        m_drain = 0;
        m_vec   = 0;
        m_done  = 1'b0;
        m_wen   = '0;
        m_w     = '0;
        m_xv    = '0;
        m_x     = '0;
        hist_v.delete();
        hist_d.delete();
        for (int i = 0; i < N; i++) begin
            hist_v.push_back(1'b0);
            hist_d.push_back('0);
        end
    endtask

    task automatic modelStep();
        mode_t            pre;
        bit               w_acc;
        bit               i_acc;
        logic [N*X_W-1:0] old_vec;
        pre    = m_mode;
        w_acc  = bus.w_v && (pre == M_IDLE || pre == M_LOAD);
        i_acc  = bus.in_v && (pre == M_STREAM);
        m_done = 1'b0;
        m_wen  = '0;
        if (w_acc) begin
            m_wen[m_rows] = 1'b1;
            m_w = bus.w_data;
            if (m_rows == N - 1) begin
                m_mode = M_STREAM;
                m_rows = 0;
                m_vec  = 0;
            end else begin
                m_rows++;
                m_mode = M_LOAD;
            end
        end
        if (i_acc) begin
            if (m_vec < 65535) m_vec++;
            if (bus.in_last) begin
                m_mode  = M_DRAIN;
                m_drain = N;
            end
        end
        if (pre == M_DRAIN) begin
            m_drain--;
            if (m_drain == 0) begin
                m_mode = M_IDLE;
                m_done = 1'b1;
            end
        end
        hist_v.push_back(i_acc);
        hist_d.push_back(bus.in_data);
        void'(hist_v.pop_front());
        void'(hist_d.pop_front());
        for (int k = 0; k < N; k++) begin
            m_xv[k] = hist_v[N-1-k];
            if (hist_v[N-1-k]) begin
                old_vec = hist_d[N-1-k];
                m_x[k*X_W +: X_W] = old_vec[k*X_W +: X_W];
            end
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk_i or negedge rst_i);
            if (!rst_i) modelReset();
            else modelStep();
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    initial begin
        forever begin
            @(negedge clk_i);
            checkOutput("w_rdy", bus.w_rdy, (m_mode == M_IDLE || m_mode == M_LOAD));
            checkOutput("in_rdy", bus.in_rdy, (m_mode == M_STREAM));
            checkOutput("busy", busy_o, (m_mode != M_IDLE));
            checkOutput("done", done_o, m_done);
            checkOutput("w_wr_en", w_wr_en_o, m_wen);
            checkOutput("x_v", x_v_o, m_xv);
            checkOutput("mac_top_v", mac_top_v_o, m_xv);
            checkOutput("x_data", x_o, m_x);
            if (m_wen != '0) checkOutput("w_data", w_o, m_w);
`ifdef FEEDER_PERF_EN
            checkOutput("vec_cnt", vec_cnt_o, m_vec);
`endif
        end
    end

    // ---------------- directed scenarios and random traffic ----------------
    bit               bubble_exp [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [N*X_W-1:0] skew_vec;

    initial begin
        bus.w_v     = 1'b0;
        bus.w_data  = '0;
        bus.in_v    = 1'b0;
        bus.in_data = '0;
        bus.in_last = 1'b0;
        rst_i       = 1'b0;
        repeat (3) @(negedge clk_i);

        // Reset state.
        checkOutput("rst_w_rdy", bus.w_rdy, 1'b1);
        checkOutput("rst_in_rdy", bus.in_rdy, 1'b0);
        checkOutput("rst_busy", busy_o, 1'b0);
        checkOutput("rst_x_v", x_v_o, 8'h00);
        checkOutput("rst_w_o", w_o, '0);
        rst_i = 1'b1;

        // Weight load: row r carries r+1 in every lane.
        for (int r = 0; r < N; r++) begin
            applyStimulus(1'b1, rowAll(r + 1), 1'b0, '0, 1'b0);
            if (r > 0) checkOutput("wload_wen", w_wr_en_o, 8'h01 << (r - 1));
        end
        applyIdle();
        checkOutput("wload_wen_last", w_wr_en_o, 8'h80);
        checkOutput("wload_w_o", w_o, rowAll(8));
        checkOutput("wload_in_rdy", bus.in_rdy, 1'b1);
        checkOutput("wload_w_rdy", bus.w_rdy, 1'b0);

        // Skew: lane k carries k+10 and appears only k+1 cycles later.
        for (int k = 0; k < N; k++) skew_vec[k*X_W +: X_W] = X_W'(k + 10);
        applyStimulus(1'b0, '0, 1'b1, skew_vec, 1'b0);
        for (int j = 1; j <= N + 1; j++) begin
            applyIdle();
            for (int k = 0; k < N; k++) begin
                checkOutput("skew_v", x_v_o[k], (j == k + 1));
                if (j == k + 1) checkOutput("skew_x", x_o[k*X_W +: X_W], X_W'(k + 10));
            end
        end

        // Bubbles and drain: vectors at T, T+2, T+3 (last).
        applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b0);
        applyIdle();
        applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b1);
        for (int j = 1; j <= N + 1; j++) begin
            applyIdle();
            if (j <= 4) checkOutput("bubble_lane3", x_v_o[3], bubble_exp[j-1]);
            checkOutput("drain_busy", busy_o, (j <= N));
            checkOutput("drain_done", done_o, (j == N + 1));
        end
        checkOutput("drain_in_rdy", bus.in_rdy, 1'b0);

        // Activations offered while idle are not taken.
        for (int j = 0; j < 3; j++) applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b1);
        for (int j = 0; j <= N; j++) begin
            applyIdle();
            checkOutput("idle_x_v", x_v_o, 8'h00);
            checkOutput("idle_busy", busy_o, 1'b0);
        end

        // Weight rows offered while streaming are not taken.
        for (int r = 0; r < N; r++) applyStimulus(1'b1, randRow(), 1'b0, '0, 1'b0);
        applyStimulus(1'b1, rowAll(5), 1'b0, '0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(1'b1, rowAll(5), 1'b0, '0, 1'b0);
            checkOutput("stream_wen", w_wr_en_o, 8'h00);
            checkOutput("stream_w_rdy", bus.w_rdy, 1'b0);
            checkOutput("stream_busy", busy_o, 1'b1);
        end

        // Reset two vectors into the stream discards everything in flight.
        applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, randVec(), 1'b0);
        applyReset();
        checkOutput("rst_mid_busy", busy_o, 1'b0);
        checkOutput("rst_mid_w_rdy", bus.w_rdy, 1'b1);
        for (int j = 0; j <= N; j++) begin
            applyIdle();
            checkOutput("rst_mid_x_v", x_v_o, 8'h00);
        end

        // Randomized traffic, including one reset mid-run.
        for (int c = 0; c < RAND_CYCLES; c++) begin
            if (c == RAND_CYCLES / 2) applyReset();
            applyStimulus(($urandom_range(0, 9) < 6), randRow(),
                          ($urandom_range(0, 9) < 6), randVec(),
                          ($urandom_range(0, 19) < 3));
        end
        applyIdle();
        repeat (N + 2) @(negedge clk_i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
